// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU control codes and sequencer states shared by alu_seq
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_NAND, OP_SLT, OP_MUL
    } op_t;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NAND = 4'b1101;

    localparam int MUL_STEPS = 32;

    // SLT is a SUB whose sign is post-processed; MUL steps through the adder
    function automatic logic [3:0] op_ctrl(input op_t op);
        return op == OP_AND  ? CTRL_AND  :
               op == OP_OR   ? CTRL_OR   :
               op == OP_NOR  ? CTRL_NOR  :
               op == OP_NAND ? CTRL_NAND :
               op == OP_SUB || op == OP_SLT ? CTRL_SUB : CTRL_ADD;
    endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving an external ripple ALU, with SLT and shift-add MUL
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_cout,
    output logic             resp_overflow,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow
);

    state_t           state;
    op_t              op;
    logic [WIDTH-1:0] a, b, acc, mcand, mplier;
    logic [4:0]       cnt;
    logic             arith, slt;

    assign cmd_ready  = state == IDLE;
    assign resp_valid = state == DONE;
    assign arith      = op == OP_ADD || op == OP_SUB;
    assign slt        = alu_result[WIDTH-1] ^ alu_overflow;

    // ALU inputs are only non-zero while an operation is in flight
    always_comb begin
        alu_src1 = state == EXEC ? a : state == MUL ? acc : '0;
        alu_src2 = state == EXEC ? b : state == MUL ? (mplier[0] ? mcand : '0) : '0;
        alu_ctrl = state == EXEC ? op_ctrl(op) : state == MUL ? CTRL_ADD : 4'b0000;
    end

    // Sequencer FSM with operand, multiply and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op            <= OP_AND;
            a             <= '0;
            b             <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            cnt           <= '0;
            resp_result   <= '0;
            resp_zero     <= 1'b0;
            resp_cout     <= 1'b0;
            resp_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op     <= op_t'(cmd_op);
                    a      <= cmd_a;
                    b      <= cmd_b;
                    acc    <= '0;
                    mcand  <= cmd_a;
                    mplier <= cmd_b;
                    cnt    <= '0;
                    state  <= op_t'(cmd_op) == OP_MUL ? MUL : EXEC;
                end
                EXEC: begin
                    resp_result   <= op == OP_SLT ? {{(WIDTH-1){1'b0}}, slt} : alu_result;
                    resp_zero     <= op == OP_SLT ? ~slt : alu_zero;
                    resp_cout     <= arith & alu_cout;
                    resp_overflow <= arith & alu_overflow;
                    state         <= DONE;
                end
                MUL: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'(MUL_STEPS - 1)) begin
                        resp_result   <= alu_result;
                        resp_zero     <= alu_result == '0;
                        resp_cout     <= 1'b0;
                        resp_overflow <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven check of alu_seq against a behavioural ripple-ALU stand-in
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        resp_zero, resp_cout, resp_overflow;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, alu_cout, alu_overflow;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .resp_cout(resp_cout), .resp_overflow(resp_overflow),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_cout(alu_cout), .alu_overflow(alu_overflow)
    );

    // Stand-in for the parent's ripple ALU: invert controls, carry-in, and/or/add
    logic [31:0] ain, bin;
    logic [32:0] sum;
    always_comb begin
        ain          = alu_ctrl[3] ? ~alu_src1 : alu_src1;
        bin          = alu_ctrl[2] ? ~alu_src2 : alu_src2;
        sum          = {1'b0, ain} + {1'b0, bin} + {32'd0, alu_ctrl[2] & alu_ctrl[1]};
        alu_result   = alu_ctrl[1:0] == 2'd0 ? ain & bin :
                       alu_ctrl[1:0] == 2'd1 ? ain | bin : sum[31:0];
        alu_zero     = alu_result == 32'd0;
        alu_cout     = sum[32];
        alu_overflow = alu_ctrl[1:0] == 2'd2 && ain[31] == bin[31] && sum[31] != ain[31];
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic        z, c, v;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 200);
        lat = lat - 1;
    endtask

    task automatic ack(input string name);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk({name, "_ready_after_ack"}, {31'd0, cmd_ready}, 32'd1);
        chk({name, "_valid_after_ack"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        vecs[0] = '{"add_ovf",  3'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1};
        vecs[1] = '{"sub_eq",   3'd3, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
        vecs[2] = '{"nor_zero", 3'd4, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};
        vecs[3] = '{"and",      3'd0, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0, 1'b0, 1'b0, 1};
        vecs[4] = '{"or",       3'd1, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0, 1'b0, 1};
        vecs[5] = '{"nand",     3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[6] = '{"slt_neg",  3'd6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
        vecs[7] = '{"slt_ovf",  3'd6, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
        vecs[8] = '{"slt_gt",   3'd6, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1};
        vecs[9] = '{"mul",      3'd7, 32'h00010003, 32'h00000005, 32'h0005000F, 1'b0, 1'b0, 1'b0, 32};

        #12;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_alu_src1", alu_src1, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            chk({vecs[i].name, "_result"}, resp_result, vecs[i].res);
            chk({vecs[i].name, "_zero"}, {31'd0, resp_zero}, {31'd0, vecs[i].z});
            chk({vecs[i].name, "_cout"}, {31'd0, resp_cout}, {31'd0, vecs[i].c});
            chk({vecs[i].name, "_ovf"}, {31'd0, resp_overflow}, {31'd0, vecs[i].v});
            ack(vecs[i].name);
        end

        issue(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        chk("mul_ones_latency", lat, 32);
        chk("mul_ones_result", resp_result, 32'h00000001);

        held = resp_result;
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_a     = 32'd100;
        cmd_b     = 32'd200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_result_stable", resp_result, held);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        resp_ready = 1'b0;
        chk("bp_release_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
            chk("idle_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
            chk("idle_alu_src2", alu_src2, 32'd0);
        end

        resp_ready = 1'b1;
        issue(3'd2, 32'd10, 32'd20, lat);
        chk("early_rdy_result", resp_result, 32'd30);
        @(negedge clk);
        chk("early_rdy_valid_drop", {31'd0, resp_valid}, 32'd0);
        chk("early_rdy_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        resp_ready = 1'b0;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd7;
        cmd_a     = 32'h00010003;
        cmd_b     = 32'd5;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mul_mid_ctrl", {28'd0, alu_ctrl}, 32'd2);
        chk("mul_mid_acc", alu_src1, 32'h0005000F);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_result", resp_result, 32'd0);
        chk("mid_rst_alu_src1", alu_src1, 32'd0);
        chk("mid_rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end

        issue(3'd2, 32'd2, 32'd3, lat);
        chk("post_rst_add_latency", lat, 1);
        chk("post_rst_add_result", resp_result, 32'd5);
        ack("post_rst_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
